// File: rtl/mem_responder.sv
// mem_responder: single-outstanding word memory with valid/ready request
// and response channels, programmable response latency and optional write
// protection of the low region (define MEM_RESPONDER_PROTECT_EN).
// Ports: clk, rst (sync, active high); req_valid/req_ready/req_we/req_addr/
// req_wdata request channel; rsp_valid/rsp_ready/rsp_rdata/rsp_err response.
module mem_responder #(
    parameter int LATENCY       = 1,
    parameter int DEPTH         = 256,
    parameter int PROTECT_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        we_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH];

    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic [7:0]  cur_addr;
    logic [31:0] cur_wdata;
    logic [AW-1:0] idx;
    logic        in_range;
    logic        prot;
    logic        ok;

    // With zero latency RESP is entered on the accept edge itself, so the
    // access must use the live request rather than the latched copy.
    always_comb begin
        cur_we    = (state == IDLE) ? req_we    : we_q;
        cur_addr  = (state == IDLE) ? req_addr  : addr_q;
        cur_wdata = (state == IDLE) ? req_wdata : wdata_q;
        idx       = cur_addr[AW-1:0];
        in_range  = {1'b0, cur_addr} < 9'(DEPTH);
    end

`ifdef MEM_RESPONDER_PROTECT_EN
    always_comb prot = cur_we && ({1'b0, cur_addr} < 9'(PROTECT_LIMIT));
`else
    logic unused_limit;
    assign unused_limit = (PROTECT_LIMIT != 0);
    always_comb prot = 1'b0;
`endif

    assign ok = in_range && !prot;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = rdata_q;
        rsp_err    = err_q;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = BUSY;
                        cnt_nx   = 4'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 8'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                err_q   <= !ok;
                rdata_q <= (ok && !cur_we) ? mem[idx] : 32'd0;
                if (ok && cur_we) mem[idx] <= cur_wdata;
            end else if (state == RESP && rsp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed table-driven bench over three configurations
// of mem_responder plus hand-written stall and reset-abort sequences.
module tb_mem_responder;

    localparam int N = 3;

`ifdef MEM_RESPONDER_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rst, req_valid, req_ready, req_we;
    logic [N-1:0] rsp_valid, rsp_ready, rsp_err;
    logic [7:0]   req_addr  [N];
    logic [31:0]  req_wdata [N];
    logic [31:0]  rsp_rdata [N];

    int tests = 0;
    int fails = 0;

    // 0: LATENCY=1 DEPTH=256, 1: LATENCY=0 DEPTH=128, 2: LATENCY=3 DEPTH=256
    mem_responder #(.LATENCY(1), .DEPTH(256), .PROTECT_LIMIT(64)) u0 (
        .clk(clk), .rst(rst[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );
    mem_responder #(.LATENCY(0), .DEPTH(128), .PROTECT_LIMIT(64)) u1 (
        .clk(clk), .rst(rst[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );
    mem_responder #(.LATENCY(3), .DEPTH(256), .PROTECT_LIMIT(64)) u2 (
        .clk(clk), .rst(rst[2]),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    typedef struct {
        int          d;
        logic        we;
        logic [7:0]  a;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t v[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic txn(input int d, input logic we, input logic [7:0] a,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int lat);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        check($sformatf("d%0d_ready_idle", d), 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        // scramble the request bus to prove the accepted fields were latched
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~a;
        req_wdata[d] = ~wd;
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rsp_rdata[d];
        er = rsp_err[d];
        @(negedge clk);
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        check($sformatf("d%0d_valid_drop", d), 32'(rsp_valid[d]), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = '1;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i]  = 8'd0;
            req_wdata[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst = '0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst%0d_ready", i), 32'(req_ready[i]), 32'd1);
            check($sformatf("rst%0d_valid", i), 32'(rsp_valid[i]), 32'd0);
            check($sformatf("rst%0d_rdata", i), rsp_rdata[i], 32'd0);
            check($sformatf("rst%0d_err", i), 32'(rsp_err[i]), 32'd0);
        end

        v.push_back('{0, 1'b1, 8'h80, 32'hDEADBEEF, 32'h0, 1'b0, 2});
        v.push_back('{0, 1'b0, 8'h80, 32'h0, 32'hDEADBEEF, 1'b0, 2});
        v.push_back('{0, 1'b1, 8'h10, 32'h5A5A5A5A, 32'h0, PROT, 2});
        v.push_back('{0, 1'b0, 8'h10, 32'h0,
                      PROT ? 32'h0 : 32'h5A5A5A5A, 1'b0, 2});
        v.push_back('{0, 1'b0, 8'hFF, 32'h0, 32'h0, 1'b0, 2});
        v.push_back('{0, 1'b1, 8'hFF, 32'hCAFEF00D, 32'h0, 1'b0, 2});
        v.push_back('{0, 1'b0, 8'hFF, 32'h0, 32'hCAFEF00D, 1'b0, 2});
        v.push_back('{1, 1'b0, 8'h05, 32'h0, 32'h0, 1'b0, 1});
        v.push_back('{1, 1'b0, 8'h80, 32'h0, 32'h0, 1'b1, 1});
        v.push_back('{1, 1'b1, 8'hFF, 32'h11111111, 32'h0, 1'b1, 1});
        v.push_back('{1, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1});
        v.push_back('{1, 1'b0, 8'h7F, 32'h0, 32'h0, 1'b0, 1});
        v.push_back('{1, 1'b1, 8'h7F, 32'hA5A5A5A5, 32'h0, 1'b0, 1});
        v.push_back('{1, 1'b0, 8'h7F, 32'h0, 32'hA5A5A5A5, 1'b0, 1});
        v.push_back('{2, 1'b0, 8'h05, 32'h0, 32'h0, 1'b0, 4});
        v.push_back('{2, 1'b1, 8'h40, 32'h01020304, 32'h0, 1'b0, 4});
        v.push_back('{2, 1'b0, 8'h40, 32'h0, 32'h01020304, 1'b0, 4});
        v.push_back('{2, 1'b1, 8'h3F, 32'h00000009, 32'h0, PROT, 4});
        v.push_back('{2, 1'b0, 8'h3F, 32'h0,
                      PROT ? 32'h0 : 32'h00000009, 1'b0, 4});

        for (int i = 0; i < v.size(); i++) begin
            txn(v[i].d, v[i].we, v[i].a, v[i].wd, rd, er, lat);
            check($sformatf("v%0d_rdata", i), rd, v[i].exp_rd);
            check($sformatf("v%0d_err", i), 32'(er), 32'(v[i].exp_err));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(v[i].exp_lat));
        end

        // stall in RESP while the request side keeps poking writes
        txn(0, 1'b1, 8'hA0, 32'h0BADF00D, rd, er, lat);
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 8'hA0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        lat = 1;
        while (!rsp_valid[0] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall_lat", 32'(lat), 32'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid[0] = ~req_valid[0];
            req_we[0]    = 1'b1;
            req_addr[0]  = 8'hA0;
            req_wdata[0] = 32'(i);
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_valid", i), 32'(rsp_valid[0]), 32'd1);
            check($sformatf("stall%0d_rdata", i), rsp_rdata[0], 32'h0BADF00D);
            check($sformatf("stall%0d_ready", i), 32'(req_ready[0]), 32'd0);
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post_stall%0d_valid", i), 32'(rsp_valid[0]), 32'd0);
            check($sformatf("post_stall%0d_ready", i), 32'(req_ready[0]), 32'd1);
            @(posedge clk);
            #1;
        end
        txn(0, 1'b0, 8'hA0, 32'h0, rd, er, lat);
        check("stall_readback", rd, 32'h0BADF00D);

        // reset while a write sits in BUSY
        txn(2, 1'b1, 8'h90, 32'h12345678, rd, er, lat);
        txn(2, 1'b0, 8'h90, 32'h0, rd, er, lat);
        check("pre_abort_rd", rd, 32'h12345678);
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 8'h90;
        req_wdata[2] = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        check("abort_busy_ready", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        rst[2] = 1'b1;
        @(posedge clk);
        #1;
        rst[2] = 1'b0;
        check("abort_ready", 32'(req_ready[2]), 32'd1);
        check("abort_rdata", rsp_rdata[2], 32'd0);
        check("abort_err", 32'(rsp_err[2]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort%0d_valid", i), 32'(rsp_valid[2]), 32'd0);
            @(posedge clk);
            #1;
        end
        txn(2, 1'b0, 8'h90, 32'h0, rd, er, lat);
        check("abort_readback", rd, 32'd0);
        check("abort_readback_err", 32'(er), 32'd0);
        check("abort_readback_lat", 32'(lat), 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
